// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master and its SCK divider.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0  = 2'b00;  // {CPOL, CPHA}
  localparam int         DATA_W_DEF = 8;

  // Bits needed to hold CLK_DIV-1 in the half-period down-counter.
  function automatic int div_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// SCK half-period divider: one-cycle tick every CLK_DIV cycles while enabled.
module spi_sck_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             CW     = div_w(CLK_DIV);
  localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Reloaded while disabled so the first tick lands CLK_DIV cycles after enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_byte.sv
// Mode-0 SPI master: one byte per handshake, MSB first, with a deselect gap between bytes.
//   state | meaning
//   IDLE  | tx_ready high, waiting for tx_valid
//   SETUP | SSEL low, first MOSI bit settling before the first rising SCK
//   XFER  | SCK toggling, 8 bits shifted out and in
//   HOLD  | SCK low, SSEL still low after the last falling edge
//   GAP   | SSEL high, enforced deselect before the next byte
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              ssel,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W);

  spi_state_t        state, state_nxt;
  logic              tick, tick_en;
  logic              accept, rise, fall, done, last_bit;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift;

  assign last_bit = (bit_cnt == BW'(DATA_W - 1));

  spi_sck_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid)                 state_nxt = SETUP;
      SETUP:   if (tick)                     state_nxt = XFER;
      XFER:    if (tick && sck && last_bit)  state_nxt = HOLD;
      HOLD:    if (tick)                     state_nxt = GAP;
      GAP:     if (tick)                     state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // The first rising edge is the SETUP tick; later ones come from XFER with SCK low.
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    tick_en  = (state != IDLE);
    accept   = tx_ready && tx_valid;
    rise     = tick && ((state == SETUP) || ((state == XFER) && !sck));
    fall     = tick && (state == XFER) && sck;
    done     = tick && (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck      <= SPI_MODE0[1];
      ssel     <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        tx_shift <= tx_data;
        mosi     <= tx_data[DATA_W-1];
        ssel     <= 1'b0;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (rise) begin
        sck      <= 1'b1;
        rx_shift <= {rx_shift[DATA_W-2:0], miso};
      end
      // No shift after the last bit so MOSI holds it through HOLD.
      if (fall) begin
        sck     <= 1'b0;
        bit_cnt <= bit_cnt + BW'(1);
        if (!last_bit) begin
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          mosi     <= tx_shift[DATA_W-2];
        end
      end
      if (done) begin
        ssel     <= 1'b1;
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte at CLK_DIV 4, 1 and 255 with loopback, constant and slave-model MISO.
module tb_spi_master_byte;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       miso;

  logic       tr [3];
  logic       rv [3];
  logic [7:0] rd [3];
  logic       by [3];
  logic       sk [3];
  logic       ss [3];
  logic       mo [3];

  int         sel;
  int         miso_mode;
  int         n_cur;
  logic       obs_tx_ready, obs_rx_valid, obs_busy, obs_sck, obs_ssel, obs_mosi;
  logic [7:0] obs_rx_data;

  int total = 0;
  int bad   = 0;

  spi_master_byte #(.CLK_DIV(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tr[0]), .tx_data(tx_data),
    .rx_valid(rv[0]), .rx_data(rd[0]), .busy(by[0]), .sck(sk[0]), .ssel(ss[0]),
    .mosi(mo[0]), .miso(miso));

  spi_master_byte #(.CLK_DIV(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tr[1]), .tx_data(tx_data),
    .rx_valid(rv[1]), .rx_data(rd[1]), .busy(by[1]), .sck(sk[1]), .ssel(ss[1]),
    .mosi(mo[1]), .miso(miso));

  spi_master_byte #(.CLK_DIV(255)) u_n255 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tr[2]), .tx_data(tx_data),
    .rx_valid(rv[2]), .rx_data(rd[2]), .busy(by[2]), .sck(sk[2]), .ssel(ss[2]),
    .mosi(mo[2]), .miso(miso));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_tx_ready = tr[sel];
    obs_rx_valid = rv[sel];
    obs_rx_data  = rd[sel];
    obs_busy     = by[sel];
    obs_sck      = sk[sel];
    obs_ssel     = ss[sel];
    obs_mosi     = mo[sel];
    case (sel)
      0:       n_cur = 4;
      1:       n_cur = 1;
      default: n_cur = 255;
    endcase
  end

  // Slave model: answers each byte with the product of its two nibbles on the next transfer.
  logic [7:0] s_rx, s_tx;
  logic       s_sck_q, s_ssel_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_rx     <= 8'h00;
      s_tx     <= 8'h00;
      s_sck_q  <= 1'b0;
      s_ssel_q <= 1'b1;
    end else begin
      if (obs_sck && !s_sck_q)   s_rx <= {s_rx[6:0], obs_mosi};
      if (!obs_sck && s_sck_q)   s_tx <= {s_tx[6:0], 1'b0};
      if (obs_ssel && !s_ssel_q) s_tx <= 8'(s_rx[7:4]) * 8'(s_rx[3:0]);
      s_sck_q  <= obs_sck;
      s_ssel_q <= obs_ssel;
    end
  end

  always_comb begin
    case (miso_mode)
      0:       miso = obs_mosi;
      1:       miso = s_tx[7];
      default: miso = 1'b1;
    endcase
  end

  // Monitor: t=1 is the cycle right after the first acceptance since the last clear.
  int         clr_seq = 0;
  int         clr_seen = 0;
  bit         started;
  int         t, rxv_cnt, rxv_t1, rxv_t2, ssel_low, rises, nfall, fall2_t, rise1_t;
  int         mosi_bad, mosi_age, hi_len, busy_bad;
  logic [7:0] rx1, rx2, mosi_cap;
  logic       busy_q = 1'b0, ssel_q = 1'b1, sck_q = 1'b0, mosi_q = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      started  = 1'b0;
      t        = 0;
      rxv_cnt  = 0;
      rxv_t1   = 0;
      rxv_t2   = 0;
      ssel_low = 0;
      rises    = 0;
      nfall    = 0;
      fall2_t  = 0;
      rise1_t  = 0;
      mosi_bad = 0;
      mosi_age = 100000;
      hi_len   = 0;
      busy_bad = 0;
      rx1      = 8'h00;
      rx2      = 8'h00;
      mosi_cap = 8'h00;
    end
    if (!started && obs_busy && !busy_q) started = 1'b1;
    mosi_age = (obs_mosi != mosi_q) ? 0 : mosi_age + 1;
    if (started) begin
      t++;
      if (!obs_ssel) ssel_low++;
      if (obs_ssel && !ssel_q && rise1_t == 0) rise1_t = t;
      if (!obs_ssel && ssel_q) begin
        nfall++;
        if (nfall == 2) fall2_t = t;
      end
      if (obs_rx_valid) begin
        rxv_cnt++;
        if (rxv_cnt == 1) begin
          rxv_t1 = t;
          rx1    = obs_rx_data;
        end else if (rxv_cnt == 2) begin
          rxv_t2 = t;
          rx2    = obs_rx_data;
        end
      end
      if (obs_sck && !sck_q) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], obs_mosi};
        if (mosi_age < n_cur) mosi_bad++;
        hi_len = 0;
      end
      if (obs_sck) begin
        hi_len++;
        if (obs_mosi != mosi_q) mosi_bad++;
      end
      if (!obs_sck && sck_q && hi_len != n_cur) mosi_bad++;
      if (t <= 18 * n_cur && (obs_tx_ready || !obs_busy)) busy_bad++;
    end
    busy_q = obs_busy;
    ssel_q = obs_ssel;
    sck_q  = obs_sck;
    mosi_q = obs_mosi;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_seq++;
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (obs_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (obs_busy) chk("timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    sel       = 0;
    miso_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sck",      obs_sck,      0);
    chk("rst_ssel",     obs_ssel,     1);
    chk("rst_mosi",     obs_mosi,     0);
    chk("rst_rx_valid", obs_rx_valid, 0);
    chk("rst_rx_data",  obs_rx_data,  0);
    chk("rst_busy",     obs_busy,     0);
    chk("rst_tx_ready", obs_tx_ready, 1);

    // Loopback, N=4
    sel = 0; miso_mode = 0;
    reset_dut();
    start(8'h35);
    wait_idle(300);
    chk("lb_rx",       obs_rx_data, 8'h35);
    chk("lb_rxv_cnt",  rxv_cnt,     1);
    chk("lb_rxv_t",    rxv_t1,      69);
    chk("lb_ssel_low", ssel_low,    68);
    chk("lb_rises",    rises,       8);
    chk("lb_mosi",     mosi_bad,    0);
    chk("lb_busy",     busy_bad,    0);

    // Nibble-product slave, N=4: answer to 0x53 comes back on the next byte
    miso_mode = 1;
    reset_dut();
    start(8'h53);
    wait_idle(300);
    chk("sl_rx1",   rx1,      8'h00);
    chk("sl_srx",   s_rx,     8'h53);
    chk("sl_rises", rises,    8);
    chk("sl_mosi",  mosi_bad, 0);
    clr_seq++;
    start(8'h00);
    wait_idle(300);
    chk("sl_rx2",   rx1,      8'h0F);

    // MISO high, N=1, tx_valid held across two bytes
    sel = 1; miso_mode = 2;
    reset_dut();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    repeat (25) @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(100);
    chk("bb_cnt",   rxv_cnt, 2);
    chk("bb_rx1",   rx1,     8'hFF);
    chk("bb_rx2",   rx2,     8'hFF);
    chk("bb_rxv1",  rxv_t1,  18);
    chk("bb_rise1", rise1_t, 18);
    chk("bb_fall2", fall2_t, 20);
    chk("bb_rxv2",  rxv_t2,  37);

    // Offer while busy is ignored, N=4
    sel = 0; miso_mode = 0;
    reset_dut();
    start(8'h0F);
    repeat (20) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    repeat (5) @(negedge clk);
    chk("aa_ready", obs_tx_ready, 0);
    repeat (5) @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(300);
    chk("aa_mosi", mosi_cap,    8'h0F);
    chk("aa_rx",   obs_rx_data, 8'h0F);
    chk("aa_cnt",  rxv_cnt,     1);
    chk("aa_busy", busy_bad,    0);

    // Reset in the high phase of bit 4, then a clean transfer
    reset_dut();
    start(8'h18);
    repeat (37) @(negedge clk);
    chk("rs_sck_pre",  obs_sck,  1);
    chk("rs_mosi_pre", obs_mosi, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_ssel", obs_ssel, 1);
    chk("rs_sck",  obs_sck,  0);
    chk("rs_mosi", obs_mosi, 0);
    chk("rs_busy", obs_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rs_rxv", rxv_cnt,     0);
    chk("rs_rxd", obs_rx_data, 0);
    clr_seq++;
    start(8'hC3);
    wait_idle(300);
    chk("rs_next_rx",  obs_rx_data, 8'hC3);
    chk("rs_next_cnt", rxv_cnt,     1);
    chk("rs_next_t",   rxv_t1,      69);

    // Largest divider, N=255
    sel = 2; miso_mode = 0;
    reset_dut();
    start(8'hA5);
    wait_idle(5000);
    chk("big_rx",    obs_rx_data, 8'hA5);
    chk("big_t",     rxv_t1,      4336);
    chk("big_low",   ssel_low,    4335);
    chk("big_rises", rises,       8);
    chk("big_mosi",  mosi_bad,    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_byte.md
# spi_master_byte

Byte-wide SPI master that drives the SPI slave link of the matrix datapath. It takes one operand byte from the system-side producer over a valid/ready handshake, serialises it on MOSI MSB-first, and samples MISO in parallel. It returns the received byte with a one-cycle valid pulse. It generates SCK, SSEL and MOSI from the system clock. SPI mode 0: SCK idles low, data is sampled on rising SCK, and SSEL is active-low.

## Interface
- CLK_DIV, default 4: SCK half-period in CLK cycles; legal range 1..255.
- DATA_W, default 8: bits per transaction; fixed at 8 for the current slave.

- CLK  in  1  system clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready.
- tx_data  in  DATA_W  byte to send; latched on acceptance.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_data  out  DATA_W  byte sampled from MISO; holds its value until the next rx_valid.
- busy  out  1  high from acceptance until the return to IDLE.
- SCK  out  1  SPI clock; idles low.
- SSEL  out  1  slave select, active-low; idles high.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in; must be synchronous to CLK (board-level guarantee).

## Operation
- FSM states and transitions:
  - IDLE → SETUP on acceptance.
  - SETUP → XFER after CLK_DIV cycles.
  - XFER → HOLD after the 16th SCK half-period.
  - HOLD → GAP after CLK_DIV cycles.
  - GAP → IDLE after CLK_DIV cycles.
- On acceptance: tx_data goes to the shift register. In the following cycle SSEL=0 and MOSI=tx_data[7].
- XFER:
  - Each rising SCK edge shifts MISO into the LSB of rx_shift.
  - Each falling SCK edge, except the 8th, shifts tx_shift left and drives the next bit on MOSI.
  - The bit counter runs 0..7 and is 3 bits wide. It wraps to 0 and is not reused beyond 8 bits.
- HOLD: SCK=0, SSEL=0, MOSI holds the last bit.
- Leaving HOLD: SSEL=1. In the same cycle rx_data<=rx_shift and rx_valid=1.
- GAP: SSEL stays high for CLK_DIV cycles. This guarantees the slave's bit counter sees a deselect between bytes.
- tx_valid while busy: ignored. There is no queueing, and tx_data is not re-sampled.
- Reset, asynchronous at any point including mid-transfer:
  - State=IDLE, SCK=0, SSEL=1, MOSI=0.
  - rx_valid=0, rx_data=0, busy=0, tx_ready=1.
  - Shift registers and counters are 0.
  - The partial byte is discarded and no rx_valid is produced.

## Timing
- Cycle 0 is the acceptance edge; N=CLK_DIV.
- SSEL falls at cycle 1.
- Bit k (k=0..7):
  - SCK rises at cycle 1+N(1+2k); MISO is sampled there.
  - SCK falls at cycle 1+N(2+2k).
- Last fall at 1+16N. SSEL rises and rx_valid pulses at 1+17N.
- tx_ready reasserts at 1+18N. Back-to-back throughput is one byte per 18N+1 cycles.
- Example, N=1: SSEL low cycles 1..17, rx_valid at 18, tx_ready at 19.
- All outputs are registered except tx_ready and busy, which are decoded from state.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - the SPI_MODE0 constant;
  - the default DATA_W;
  - a clog2-based width for the divider counter.
- Sub-module spi_sck_tick: a half-period divider.
  - Ports: CLK, RST_N, en, tick.
  - Emits a one-cycle tick every CLK_DIV cycles while en is high; clears when en is low.
  - The master FSM advances SCK, state and bit count only on tick.

## Test plan
- Loopback (MISO tied to MOSI), N=4, send 0x35 → rx_data=0x35; rx_valid exactly once, at cycle 69; SSEL low for 68 cycles.
- Behavioural slave model returning nibble product, send 0x53 → rx_data=0x0F. Exactly 8 SCK rising edges; MOSI stable ≥N cycles around each rising edge.
- MISO held at 1, N=1, two back-to-back bytes (tx_valid held high) → rx_data=0xFF twice. Second SSEL fall at cycle 20; SSEL high ≥1 cycle between bytes.
- tx_valid with 0xAA asserted during XFER of 0x0F → ignored; only 0x0F appears on MOSI; busy stays high; tx_ready=0 until GAP ends.
- RST_N pulsed low at bit 4 of a transfer:
  - during reset, SSEL=1, SCK=0, MOSI=0 immediately (asynchronously);
  - no rx_valid; rx_data=0;
  - the next transfer of 0xC3 completes correctly.
- N=255 single byte → rx_valid at cycle 4336; counter width has no overflow.
